// File: rtl/atm_multi_account_ctrl.sv
// ATM transaction controller for NUM_ACCTS on-chip accounts: card session, PIN check with
// per-account lockout, inactivity timeout and balance/withdraw/deposit/transfer commands.
module atm_multi_account_ctrl #(
   parameter int unsigned NUM_ACCTS   = 4,
   parameter int unsigned BAL_W       = 32,
   parameter int unsigned PIN_W       = 14,
   parameter int unsigned MAX_TRIES   = 3,
   parameter int unsigned INIT_BAL    = 100000,
   parameter int unsigned DEFAULT_PIN = 8030,
   parameter int unsigned TIMEOUT_CYC = 1024,
   localparam int unsigned IDX_W      = $clog2(NUM_ACCTS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             card_in,
   input  logic [IDX_W-1:0] card_idx,
   input  logic             pin_valid,
   input  logic [PIN_W-1:0] pin,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [BAL_W-1:0] cmd_amount,
   input  logic [IDX_W-1:0] cmd_dest,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [2:0]       rsp_status,
   output logic [BAL_W-1:0] rsp_balance,
   output logic             card_eject,
   output logic [2:0]       tries_left,
   input  logic             cfg_we,
   input  logic [IDX_W-1:0] cfg_idx,
   input  logic [PIN_W-1:0] cfg_pin,
   input  logic [BAL_W-1:0] cfg_bal
);

   typedef enum logic [2:0] {StIdle, StPin, StHome, StExec, StResp, StEject} state_e;

   localparam int unsigned    TMR_W     = $clog2(TIMEOUT_CYC) + 1;
   localparam logic [TMR_W-1:0] TmrLast = TMR_W'(TIMEOUT_CYC - 1);
   localparam logic [IDX_W:0] NumAcctsW = (IDX_W + 1)'(NUM_ACCTS);
   localparam logic [2:0]     MaxTriesW = 3'(MAX_TRIES);
   localparam logic [BAL_W-1:0] InitBal = BAL_W'(INIT_BAL);
   localparam logic [PIN_W-1:0] InitPin = PIN_W'(DEFAULT_PIN);

   localparam logic [2:0] RspOk      = 3'd0;
   localparam logic [2:0] RspInsuff  = 3'd1;
   localparam logic [2:0] RspOvf     = 3'd2;
   localparam logic [2:0] RspBadAcct = 3'd3;
   localparam logic [2:0] RspBadOp   = 3'd4;
   localparam logic [2:0] RspLocked  = 3'd5;
   localparam logic [2:0] RspTimeout = 3'd6;
   localparam logic [2:0] RspBadPin  = 3'd7;

   state_e             state_q, state_d, next_q, next_d;
   logic [IDX_W-1:0]   idx_q, idx_d, dest_q, dest_d;
   logic [2:0]         op_q, op_d;
   logic [BAL_W-1:0]   amt_q, amt_d;
   logic [BAL_W-1:0]   bal_q [NUM_ACCTS];
   logic [BAL_W-1:0]   bal_d [NUM_ACCTS];
   logic [PIN_W-1:0]   pin_q [NUM_ACCTS];
   logic [PIN_W-1:0]   pin_d [NUM_ACCTS];
   logic [NUM_ACCTS-1:0] lock_q, lock_d;
   logic [2:0]         tries_q, tries_d;
   logic [TMR_W-1:0]   tmr_q, tmr_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic [2:0]         rsp_status_q, rsp_status_d;
   logic [BAL_W-1:0]   rsp_balance_q, rsp_balance_d;
   logic               eject_q, eject_d;
   logic               cmd_ready_q, cmd_ready_d;

   logic [BAL_W-1:0]   src_bal, dst_bal;
   logic [BAL_W:0]     dep_sum, xfer_sum;
   logic               dest_ok, card_ok, cfg_ok;

   assign src_bal  = bal_q[idx_q];
   assign dst_bal  = bal_q[dest_q];
   assign dep_sum  = {1'b0, src_bal} + {1'b0, amt_q};
   assign xfer_sum = {1'b0, dst_bal} + {1'b0, amt_q};
   assign dest_ok  = {1'b0, dest_q} < NumAcctsW;
   assign card_ok  = {1'b0, card_idx} < NumAcctsW;
   assign cfg_ok   = {1'b0, cfg_idx} < NumAcctsW;

   always_comb begin
      state_d       = state_q;
      next_d        = next_q;
      idx_d         = idx_q;
      dest_d        = dest_q;
      op_d          = op_q;
      amt_d         = amt_q;
      bal_d         = bal_q;
      pin_d         = pin_q;
      lock_d        = lock_q;
      tries_d       = tries_q;
      tmr_d         = tmr_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_status_d  = rsp_status_q;
      rsp_balance_d = rsp_balance_q;

      case (state_q)
         StIdle: begin
            if (cfg_we && cfg_ok) begin
               pin_d[cfg_idx]  = cfg_pin;
               bal_d[cfg_idx]  = cfg_bal;
               lock_d[cfg_idx] = 1'b0;
            end
            if (card_in) begin
               idx_d = card_idx;
               if (!card_ok || lock_q[card_idx]) begin
                  state_d       = StResp;
                  next_d        = StEject;
                  rsp_valid_d   = 1'b1;
                  rsp_status_d  = card_ok ? RspLocked : RspBadAcct;
                  rsp_balance_d = '0;
               end else begin
                  state_d = StPin;
                  tries_d = MaxTriesW;
               end
            end
         end
         StPin: begin
            if (pin_valid) begin
               if (pin == pin_q[idx_q]) begin
                  state_d = StHome;
               end else begin
                  tries_d       = tries_q - 3'd1;
                  state_d       = StResp;
                  rsp_valid_d   = 1'b1;
                  rsp_status_d  = RspBadPin;
                  rsp_balance_d = '0;
                  if (tries_q <= 3'd1) begin
                     lock_d[idx_q] = 1'b1;
                     next_d        = StEject;
                  end else begin
                     next_d = StPin;
                  end
               end
            end else if (tmr_q == TmrLast) begin
               state_d       = StResp;
               next_d        = StEject;
               rsp_valid_d   = 1'b1;
               rsp_status_d  = RspTimeout;
               rsp_balance_d = '0;
            end
         end
         StHome: begin
            if (cmd_valid && cmd_ready_q) begin
               state_d = StExec;
               op_d    = cmd_op;
               amt_d   = cmd_amount;
               dest_d  = cmd_dest;
            end else if (tmr_q == TmrLast) begin
               state_d       = StResp;
               next_d        = StEject;
               rsp_valid_d   = 1'b1;
               rsp_status_d  = RspTimeout;
               rsp_balance_d = src_bal;
            end
         end
         StExec: begin
            state_d       = StResp;
            next_d        = StHome;
            rsp_valid_d   = 1'b1;
            rsp_status_d  = RspOk;
            rsp_balance_d = src_bal;
            case (op_q)
               3'b000: next_d = StEject;
               3'b001: ;
               3'b010: begin
                  if (amt_q > src_bal) begin
                     rsp_status_d = RspInsuff;
                  end else begin
                     bal_d[idx_q]  = src_bal - amt_q;
                     rsp_balance_d = src_bal - amt_q;
                  end
               end
               3'b011: begin
                  if (dep_sum[BAL_W]) begin
                     rsp_status_d = RspOvf;
                  end else begin
                     bal_d[idx_q]  = dep_sum[BAL_W-1:0];
                     rsp_balance_d = dep_sum[BAL_W-1:0];
                  end
               end
               3'b100: begin
                  // Both accounts update together only after every check has passed.
                  if (!dest_ok || dest_q == idx_q) begin
                     rsp_status_d = RspBadAcct;
                  end else if (amt_q > src_bal) begin
                     rsp_status_d = RspInsuff;
                  end else if (xfer_sum[BAL_W]) begin
                     rsp_status_d = RspOvf;
                  end else begin
                     bal_d[idx_q]  = src_bal - amt_q;
                     bal_d[dest_q] = xfer_sum[BAL_W-1:0];
                     rsp_balance_d = src_bal - amt_q;
                  end
               end
               default: rsp_status_d = RspBadOp;
            endcase
         end
         StResp: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = next_q;
            end
         end
         StEject: state_d = StIdle;
         default: state_d = StIdle;
      endcase

      // Any pin entry or command handshake leaves the state, so entry clearing covers both.
      if (state_d != state_q) begin
         tmr_d = '0;
      end else if (state_q == StPin || state_q == StHome) begin
         tmr_d = tmr_q + TMR_W'(1);
      end

      eject_d     = (state_d == StEject);
      cmd_ready_d = (state_d == StHome);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= StIdle;
         next_q        <= StIdle;
         idx_q         <= '0;
         dest_q        <= '0;
         op_q          <= '0;
         amt_q         <= '0;
         for (int i = 0; i < NUM_ACCTS; i++) begin
            bal_q[i] <= InitBal;
            pin_q[i] <= InitPin;
         end
         lock_q        <= '0;
         tries_q       <= MaxTriesW;
         tmr_q         <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_status_q  <= '0;
         rsp_balance_q <= '0;
         eject_q       <= 1'b0;
         cmd_ready_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         next_q        <= next_d;
         idx_q         <= idx_d;
         dest_q        <= dest_d;
         op_q          <= op_d;
         amt_q         <= amt_d;
         bal_q         <= bal_d;
         pin_q         <= pin_d;
         lock_q        <= lock_d;
         tries_q       <= tries_d;
         tmr_q         <= tmr_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_status_q  <= rsp_status_d;
         rsp_balance_q <= rsp_balance_d;
         eject_q       <= eject_d;
         cmd_ready_q   <= cmd_ready_d;
      end
   end

   assign cmd_ready   = cmd_ready_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_status  = rsp_status_q;
   assign rsp_balance = rsp_balance_q;
   assign card_eject  = eject_q;
   assign tries_left  = tries_q;

endmodule

// File: tb/tb_atm_multi_account_ctrl.sv
// Directed testbench for atm_multi_account_ctrl: sessions, commands, lockout, transfer,
// timeout and mid-session reset, with hand-computed expectations.
module tb_atm_multi_account_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        card_in = 1'b0;
   logic [1:0]  card_idx = '0;
   logic        pin_valid = 1'b0;
   logic [13:0] pin = '0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [2:0]  cmd_op = '0;
   logic [31:0] cmd_amount = '0;
   logic [1:0]  cmd_dest = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [2:0]  rsp_status;
   logic [31:0] rsp_balance;
   logic        card_eject;
   logic [2:0]  tries_left;
   logic        cfg_we = 1'b0;
   logic [1:0]  cfg_idx = '0;
   logic [13:0] cfg_pin = '0;
   logic [31:0] cfg_bal = '0;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] amt;
      logic [1:0]  dest;
      logic [2:0]  st;
      logic [31:0] bal;
   } vec_t;

   atm_multi_account_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .card_in     (card_in),
      .card_idx    (card_idx),
      .pin_valid   (pin_valid),
      .pin         (pin),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_amount  (cmd_amount),
      .cmd_dest    (cmd_dest),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_status  (rsp_status),
      .rsp_balance (rsp_balance),
      .card_eject  (card_eject),
      .tries_left  (tries_left),
      .cfg_we      (cfg_we),
      .cfg_idx     (cfg_idx),
      .cfg_pin     (cfg_pin),
      .cfg_bal     (cfg_bal)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Stimulus helpers: inputs change and outputs are sampled on the falling edge.
   task automatic insert_card(input logic [1:0] idx);
      @(negedge clk);
      card_in  = 1'b1;
      card_idx = idx;
      @(negedge clk);
      card_in  = 1'b0;
   endtask

   task automatic enter_pin(input logic [13:0] p);
      @(negedge clk);
      pin_valid = 1'b1;
      pin       = p;
      @(negedge clk);
      pin_valid = 1'b0;
   endtask

   task automatic cfg_write(input logic [1:0] idx, input logic [13:0] p, input logic [31:0] b);
      @(negedge clk);
      cfg_we  = 1'b1;
      cfg_idx = idx;
      cfg_pin = p;
      cfg_bal = b;
      @(negedge clk);
      cfg_we  = 1'b0;
   endtask

   task automatic send_cmd(input logic [2:0] op, input logic [31:0] amt, input logic [1:0] dest);
      bit rdy = 0;
      for (int i = 0; i < 50; i++) begin
         if (cmd_ready === 1'b1) begin
            rdy = 1;
            break;
         end
         @(negedge clk);
      end
      if (!rdy) begin
         n_cmp++;
         n_bad++;
         $display("FAIL cmd_ready_wait: cmd_ready low for 50 cycles, required 1");
      end
      cmd_valid  = 1'b1;
      cmd_op     = op;
      cmd_amount = amt;
      cmd_dest   = dest;
      @(negedge clk);
      cmd_valid  = 1'b0;
   endtask

   task automatic wait_rsp(input int max_cyc, output logic [2:0] st, output logic [31:0] bal);
      bit got = 0;
      for (int i = 0; i < max_cyc; i++) begin
         if (rsp_valid === 1'b1) begin
            got = 1;
            break;
         end
         @(negedge clk);
      end
      if (!got) begin
         n_cmp++;
         n_bad++;
         $display("FAIL rsp_wait: rsp_valid low for %0d cycles, required 1", max_cyc);
         st  = 'x;
         bal = 'x;
      end else begin
         st        = rsp_status;
         bal       = rsp_balance;
         rsp_ready = 1'b1;
         @(negedge clk);
         rsp_ready = 1'b0;
      end
   endtask

   task automatic wait_eject(output bit got);
      got = 0;
      for (int i = 0; i < 20; i++) begin
         if (card_eject === 1'b1) begin
            got = 1;
            break;
         end
         @(negedge clk);
      end
      if (!got) begin
         n_cmp++;
         n_bad++;
         $display("FAIL eject_wait: card_eject low for 20 cycles, required 1");
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({cmd_ready, rsp_valid, card_eject} !== 3'b000) begin
         n_bad++;
         $display("FAIL reset_ctl: ready/valid/eject %b, required 000",
                  {cmd_ready, rsp_valid, card_eject});
      end
      n_cmp++;
      if (tries_left !== 3'd3) begin
         n_bad++;
         $display("FAIL reset_tries: tries_left %0d, required 3", tries_left);
      end
      n_cmp++;
      if (rsp_status !== 3'd0 || rsp_balance !== 32'd0) begin
         n_bad++;
         $display("FAIL reset_rsp: status %0d bal %0d, required 0 0", rsp_status, rsp_balance);
      end
      reset = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (cmd_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL idle_ready: cmd_ready %b, required 0", cmd_ready);
      end
   endtask

   task automatic test_session();
      logic [2:0]  st;
      logic [31:0] bal;
      bit          got;
      insert_card(2'd1);
      n_cmp++;
      if (tries_left !== 3'd3 || cmd_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL pin_entry: tries %0d ready %b, required 3 0", tries_left, cmd_ready);
      end
      enter_pin(14'd8030);
      n_cmp++;
      if (cmd_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL home_ready: cmd_ready %b, required 1", cmd_ready);
      end
      send_cmd(3'b001, 32'd0, 2'd0);
      n_cmp++;
      if (rsp_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL latency_n1: rsp_valid %b one cycle after handshake, required 0", rsp_valid);
      end
      @(negedge clk);
      n_cmp++;
      if (rsp_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL latency_n2: rsp_valid %b two cycles after handshake, required 1", rsp_valid);
      end
      wait_rsp(10, st, bal);
      n_cmp++;
      if (st !== 3'd0 || bal !== 32'd100000) begin
         n_bad++;
         $display("FAIL balance: status %0d bal %0d, required 0 100000", st, bal);
      end
      send_cmd(3'b000, 32'd0, 2'd0);
      wait_rsp(10, st, bal);
      n_cmp++;
      if (st !== 3'd0) begin
         n_bad++;
         $display("FAIL exit: status %0d, required 0", st);
      end
      wait_eject(got);
      @(negedge clk);
      n_cmp++;
      if (card_eject !== 1'b0) begin
         n_bad++;
         $display("FAIL eject_width: card_eject %b in second cycle, required 0", card_eject);
      end
   endtask

   task automatic test_commands();
      vec_t        v [7];
      logic [2:0]  st;
      logic [31:0] bal;
      bit          got;
      v[0] = '{3'b010, 32'd100001,     2'd0, 3'd1, 32'd100000};
      v[1] = '{3'b010, 32'd100000,     2'd0, 3'd0, 32'd0};
      v[2] = '{3'b011, 32'd1,          2'd0, 3'd0, 32'd1};
      v[3] = '{3'b011, 32'hFFFF_FFFF,  2'd0, 3'd2, 32'd1};
      v[4] = '{3'b011, 32'd0,          2'd0, 3'd0, 32'd1};
      v[5] = '{3'b101, 32'd7,          2'd0, 3'd4, 32'd1};
      v[6] = '{3'b001, 32'd0,          2'd0, 3'd0, 32'd1};
      insert_card(2'd1);
      enter_pin(14'd8030);
      for (int i = 0; i < 7; i++) begin
         send_cmd(v[i].op, v[i].amt, v[i].dest);
         wait_rsp(10, st, bal);
         n_cmp++;
         if (st !== v[i].st || bal !== v[i].bal) begin
            n_bad++;
            $display("FAIL cmd_%0d: status %0d bal %0d, required %0d %0d",
                     i, st, bal, v[i].st, v[i].bal);
         end
      end
      send_cmd(3'b000, 32'd0, 2'd0);
      wait_rsp(10, st, bal);
      wait_eject(got);
      @(negedge clk);
   endtask

   task automatic test_lockout();
      logic [2:0]  st;
      logic [31:0] bal;
      bit          got;
      insert_card(2'd1);
      for (int k = 0; k < 3; k++) begin
         enter_pin(14'd1234);
         n_cmp++;
         if (tries_left !== 3'(2 - k)) begin
            n_bad++;
            $display("FAIL tries_%0d: tries_left %0d, required %0d", k, tries_left, 2 - k);
         end
         wait_rsp(10, st, bal);
         n_cmp++;
         if (st !== 3'd7) begin
            n_bad++;
            $display("FAIL bad_pin_%0d: status %0d, required 7", k, st);
         end
      end
      wait_eject(got);
      @(negedge clk);
      insert_card(2'd1);
      wait_rsp(10, st, bal);
      n_cmp++;
      if (st !== 3'd5) begin
         n_bad++;
         $display("FAIL locked: status %0d, required 5", st);
      end
      wait_eject(got);
      @(negedge clk);
      cfg_write(2'd1, 14'd8030, 32'd100000);
      insert_card(2'd1);
      enter_pin(14'd8030);
      n_cmp++;
      if (cmd_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL unlock: cmd_ready %b after cfg write, required 1", cmd_ready);
      end
      send_cmd(3'b001, 32'd0, 2'd0);
      wait_rsp(10, st, bal);
      n_cmp++;
      if (st !== 3'd0 || bal !== 32'd100000) begin
         n_bad++;
         $display("FAIL cfg_bal: status %0d bal %0d, required 0 100000", st, bal);
      end
      send_cmd(3'b000, 32'd0, 2'd0);
      wait_rsp(10, st, bal);
      wait_eject(got);
      @(negedge clk);
   endtask

   task automatic test_transfer();
      vec_t        v [6];
      logic [2:0]  st;
      logic [31:0] bal;
      bit          got;
      v[0] = '{3'b100, 32'd500,    2'd0, 3'd3, 32'd100000};
      v[1] = '{3'b100, 32'd500,    2'd2, 3'd0, 32'd99500};
      v[2] = '{3'b100, 32'd200000, 2'd2, 3'd1, 32'd99500};
      v[3] = '{3'b100, 32'd0,      2'd3, 3'd0, 32'd99500};
      v[4] = '{3'b100, 32'd15,     2'd3, 3'd0, 32'd99485};
      v[5] = '{3'b100, 32'd1,      2'd3, 3'd2, 32'd99485};
      cfg_write(2'd3, 14'd8030, 32'hFFFF_FFF0);
      insert_card(2'd0);
      enter_pin(14'd8030);
      for (int i = 0; i < 6; i++) begin
         send_cmd(v[i].op, v[i].amt, v[i].dest);
         wait_rsp(10, st, bal);
         n_cmp++;
         if (st !== v[i].st || bal !== v[i].bal) begin
            n_bad++;
            $display("FAIL xfer_%0d: status %0d bal %0d, required %0d %0d",
                     i, st, bal, v[i].st, v[i].bal);
         end
      end
      send_cmd(3'b000, 32'd0, 2'd0);
      wait_rsp(10, st, bal);
      wait_eject(got);
      @(negedge clk);
      insert_card(2'd2);
      enter_pin(14'd8030);
      send_cmd(3'b001, 32'd0, 2'd0);
      wait_rsp(10, st, bal);
      n_cmp++;
      if (st !== 3'd0 || bal !== 32'd100500) begin
         n_bad++;
         $display("FAIL xfer_dest: status %0d bal %0d, required 0 100500", st, bal);
      end
      send_cmd(3'b000, 32'd0, 2'd0);
      wait_rsp(10, st, bal);
      wait_eject(got);
      @(negedge clk);
   endtask

   task automatic test_timeout();
      int cnt = 0;
      bit seen = 0;
      bit got;
      insert_card(2'd3);
      enter_pin(14'd8030);
      for (int i = 0; i < 1100; i++) begin
         if (rsp_valid === 1'b1) begin
            seen = 1;
            break;
         end
         @(negedge clk);
         cnt++;
      end
      n_cmp++;
      if (!seen || cnt != 1024) begin
         n_bad++;
         $display("FAIL timeout_time: rsp after %0d idle cycles (seen %0d), required 1024",
                  cnt, seen);
      end
      for (int i = 0; i < 10; i++) begin
         n_cmp++;
         if (rsp_valid !== 1'b1 || rsp_status !== 3'd6 || rsp_balance !== 32'hFFFF_FFFF) begin
            n_bad++;
            $display("FAIL rsp_hold_%0d: valid %b status %0d bal %0h, required 1 6 ffffffff",
                     i, rsp_valid, rsp_status, rsp_balance);
         end
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      wait_eject(got);
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic [2:0]  st;
      logic [31:0] bal;
      bit          got;
      insert_card(2'd0);
      enter_pin(14'd8030);
      cfg_write(2'd0, 14'd0, 32'd5);
      send_cmd(3'b001, 32'd0, 2'd0);
      wait_rsp(10, st, bal);
      n_cmp++;
      if (st !== 3'd0 || bal !== 32'd99485) begin
         n_bad++;
         $display("FAIL cfg_in_home: status %0d bal %0d, required 0 99485", st, bal);
      end
      send_cmd(3'b010, 32'd1000, 2'd0);
      reset = 1'b1;
      #1;
      n_cmp++;
      if ({rsp_valid, card_eject, cmd_ready} !== 3'b000) begin
         n_bad++;
         $display("FAIL reset_exec: valid/eject/ready %b, required 000",
                  {rsp_valid, card_eject, cmd_ready});
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_cmp++;
         if (card_eject !== 1'b0 || rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL no_eject_%0d: eject %b valid %b, required 0 0", i, card_eject,
                     rsp_valid);
         end
      end
      insert_card(2'd0);
      enter_pin(14'd8030);
      send_cmd(3'b001, 32'd0, 2'd0);
      wait_rsp(10, st, bal);
      n_cmp++;
      if (st !== 3'd0 || bal !== 32'd100000) begin
         n_bad++;
         $display("FAIL reset_bal: status %0d bal %0d, required 0 100000", st, bal);
      end
      send_cmd(3'b000, 32'd0, 2'd0);
      wait_rsp(10, st, bal);
      wait_eject(got);
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_session();
      test_commands();
      test_lockout();
      test_transfer();
      test_timeout();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
